// File: rtl/p2s_pkg.sv
// p2s_pkg: shared state type, counter-width helper and idle-level default for parallel_to_serial
package p2s_pkg;
  typedef enum logic {IDLE, SHIFT} p2s_state_t;
  localparam logic IDLE_LEVEL_DEF = 1'b0;
  function automatic int p2s_cnt_w(input int width);
    return $clog2(width);
  endfunction
endpackage

// File: rtl/p2s_hold_buffer.sv
// p2s_hold_buffer: one-word holding register that lets the next word queue behind the word on the wire
module p2s_hold_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] D,
  input  logic             VALID,
  input  logic             in_shift,
  input  logic             last_ce,
  output logic             ready,
  output logic             full,
  output logic [WIDTH-1:0] data
);
  logic             full_q, full_d, wr;
  logic [WIDTH-1:0] hold_q, hold_d;
  // an accept on the completing edge bypasses the buffer straight into the shifter
  always_comb begin
    wr     = VALID && !full_q && in_shift && !last_ce;
    hold_d = wr ? D : hold_q;
    full_d = wr | (full_q & !last_ce);
  end
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      full_q <= 1'b0;
      hold_q <= '0;
    end else begin
      full_q <= full_d;
      hold_q <= hold_d;
    end
  assign ready = !full_q;
  assign full  = full_q;
  assign data  = hold_q;
endmodule

// File: rtl/parallel_to_serial.sv
// parallel_to_serial: valid/ready word in, MSB-first serial out, one bit per CE strobe.
// Define P2S_DOUBLE_BUFFER_EN for a holding register that streams words with no gap.
module parallel_to_serial
  import p2s_pkg::*;
#(
  parameter int   WIDTH      = 8,
  parameter logic IDLE_LEVEL = IDLE_LEVEL_DEF
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] D,
  input  logic             VALID,
  output logic             READY,
  input  logic             CE,
  output logic             Q,
  output logic             FRAME,
  output logic             DONE
);
  localparam int CW = p2s_cnt_w(WIDTH);
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);
  p2s_state_t       state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d, next_word;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             q_q, q_d, frame_q, frame_d, done_q, done_d;
  logic             accept, reload;
  assign accept = VALID && READY;
`ifdef P2S_DOUBLE_BUFFER_EN
  logic             last_ce, hold_full;
  logic [WIDTH-1:0] hold_data;
  assign last_ce = (state_q == SHIFT) && CE && (cnt_q == '0);
  p2s_hold_buffer #(.WIDTH(WIDTH)) u_hold (
    .CLK(CLK), .RST(RST), .D(D), .VALID(VALID),
    .in_shift(state_q == SHIFT), .last_ce(last_ce),
    .ready(READY), .full(hold_full), .data(hold_data)
  );
  assign next_word = hold_full ? hold_data : D;
  assign reload    = hold_full | accept;
`else
  assign READY     = (state_q == IDLE);
  assign next_word = D;
  assign reload    = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    frame_d = frame_q;
    done_d  = 1'b0;
    if (state_q == IDLE) begin
      if (accept) begin
        state_d = SHIFT;
        shreg_d = next_word;
        cnt_d   = CNT_MAX;
        q_d     = next_word[WIDTH-1];
        frame_d = 1'b1;
      end
    end else if (CE) begin
      if (cnt_q != '0) begin
        shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
        cnt_d   = cnt_q - 1'b1;
        q_d     = shreg_q[WIDTH-2];
      end else begin
        done_d = 1'b1;
        if (reload) begin
          shreg_d = next_word;
          cnt_d   = CNT_MAX;
          q_d     = next_word[WIDTH-1];
        end else begin
          state_d = IDLE;
          q_d     = IDLE_LEVEL;
          frame_d = 1'b0;
        end
      end
    end
  end
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      q_q     <= IDLE_LEVEL;
      frame_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      frame_q <= frame_d;
      done_q  <= done_d;
    end
  assign Q     = q_q;
  assign FRAME = frame_q;
  assign DONE  = done_q;
endmodule

// File: tb/tb_parallel_to_serial.sv
// tb_parallel_to_serial: directed self-checking bench with a looped-back serial receiver
module tb_parallel_to_serial;
  logic       CLK = 1'b0;
  logic       RST, VALID, CE, READY, Q, FRAME, DONE;
  logic [7:0] D, rx, w;
  logic [15:0] w16;
  int n_cmp = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  always @(posedge CLK) if (CE && FRAME) rx <= {rx[6:0], Q};

  parallel_to_serial #(.WIDTH(8), .IDLE_LEVEL(1'b0)) dut (
    .CLK(CLK), .RST(RST), .D(D), .VALID(VALID), .READY(READY),
    .CE(CE), .Q(Q), .FRAME(FRAME), .DONE(DONE)
  );

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] wd, input string tag);
    D = wd; VALID = 1'b1; CE = 1'b1;
    step();
    VALID = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk1({tag, "_q"}, Q, wd[7-i]);
      chk1({tag, "_frame"}, FRAME, 1'b1);
      chk1({tag, "_done_early"}, DONE, 1'b0);
      step();
    end
    chk1({tag, "_done"}, DONE, 1'b1);
    chk1({tag, "_frame_end"}, FRAME, 1'b0);
    chk1({tag, "_q_idle"}, Q, 1'b0);
    chk8({tag, "_rx"}, rx, wd);
  endtask

  initial begin
    RST = 1'b1; D = '0; VALID = 1'b0; CE = 1'b0; rx = '0;
    #12;
    chk1("rst_ready", READY, 1'b1);
    chk1("rst_q", Q, 1'b0);
    chk1("rst_frame", FRAME, 1'b0);
    chk1("rst_done", DONE, 1'b0);
    RST = 1'b0;

    send(8'hA5, "t1");
    step();
    chk1("t1_done_pulse", DONE, 1'b0);

    D = 8'h81; VALID = 1'b1; CE = 1'b0; w = 8'h81;
    step();
    VALID = 1'b0;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 3; j++) begin
        chk1("t2_q", Q, w[7-i]);
        chk1("t2_frame", FRAME, 1'b1);
        chk1("t2_done_early", DONE, 1'b0);
        CE = (j == 2);
        step();
      end
    CE = 1'b0;
    chk1("t2_done", DONE, 1'b1);
    chk1("t2_frame_end", FRAME, 1'b0);
    chk8("t2_rx", rx, 8'h81);

`ifndef P2S_DOUBLE_BUFFER_EN
    w = 8'h99; D = w; VALID = 1'b1; CE = 1'b1;
    step();
    D = 8'h0F;
    for (int i = 0; i < 8; i++) begin
      chk1("t3_ready_busy", READY, 1'b0);
      chk1("t3_q_first", Q, w[7-i]);
      step();
    end
    chk1("t3_done", DONE, 1'b1);
    chk1("t3_frame_end", FRAME, 1'b0);
    chk1("t3_ready_idle", READY, 1'b1);
    step();
    VALID = 1'b0; w = 8'h0F;
    chk1("t3_frame_start", FRAME, 1'b1);
    for (int i = 0; i < 8; i++) begin
      chk1("t3_q_second", Q, w[7-i]);
      step();
    end
    chk1("t3_done2", DONE, 1'b1);
    chk8("t3_rx", rx, 8'h0F);
`else
    w16 = 16'h3CC3; D = 8'h3C; VALID = 1'b1; CE = 1'b1;
    step();
    for (int i = 0; i < 16; i++) begin
      chk1("t4_q", Q, w16[15-i]);
      chk1("t4_frame", FRAME, 1'b1);
      chk1("t4_done", DONE, i == 8);
      chk1("t4_ready", READY, (i == 0) || (i >= 8));
      if (i == 0) D = 8'hC3; else VALID = 1'b0;
      step();
    end
    chk1("t4_done_end", DONE, 1'b1);
    chk1("t4_frame_end", FRAME, 1'b0);
    chk8("t4_rx", rx, 8'hC3);
`endif

    step();
    D = 8'hFF; VALID = 1'b1; CE = 1'b1;
    step();
    VALID = 1'b0;
    repeat (3) step();
    chk1("t5_frame_mid", FRAME, 1'b1);
    chk1("t5_q_mid", Q, 1'b1);
    #2 RST = 1'b1;
    #1;
    chk1("t5_q_async", Q, 1'b0);
    chk1("t5_frame_async", FRAME, 1'b0);
    chk1("t5_done_async", DONE, 1'b0);
    chk1("t5_ready_async", READY, 1'b1);
    RST = 1'b0;
    step();
    chk1("t5_no_done", DONE, 1'b0);
    chk1("t5_idle_frame", FRAME, 1'b0);
    send(8'h55, "t5");

    w = 8'hB4; D = w; VALID = 1'b1; CE = 1'b1;
    step();
    VALID = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk1("t6_q_pre", Q, w[7-i]);
      step();
    end
    CE = 1'b0;
    for (int k = 0; k < 10; k++) begin
      chk1("t6_q_frozen", Q, w[4]);
      chk1("t6_frame_frozen", FRAME, 1'b1);
      chk1("t6_done_frozen", DONE, 1'b0);
      step();
    end
    CE = 1'b1;
    for (int i = 3; i < 8; i++) begin
      chk1("t6_q_post", Q, w[7-i]);
      chk1("t6_done_early", DONE, 1'b0);
      step();
    end
    chk1("t6_done", DONE, 1'b1);
    chk8("t6_rx", rx, 8'hB4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/parallel_to_serial.md
Name: parallel_to_serial

Overview:
N-bit parallel-to-serial transmitter, the transmit end of the team's serial-to-parallel shift link. It accepts a word through a valid/ready handshake and shifts it out MSB-first, one bit per CE strobe. A serial-to-parallel receiver sharing CLK and CE, sampling Q, reassembles the word in its original bit order. It sits between word-wide producers (register blocks, FIFOs) and single-wire serial links.

Parameters:
WIDTH, 8, word length in bits; must be >= 2.
IDLE_LEVEL, 1'b0, level driven on Q when no word is being shifted.

Ports:
CLK  input  1  clock; all state changes on rising edge.
RST  input  1  asynchronous reset, active high.
D  input  WIDTH  parallel word to transmit; sampled when VALID && READY.
VALID  input  1  source offers D; source holds D stable until accepted.
READY  output  1  transmitter can accept a word this cycle.
CE  input  1  bit-rate strobe, active high; one bit completes per CE cycle.
Q  output  1  serial output, MSB first.
FRAME  output  1  high while a word is on Q.
DONE  output  1  one-cycle pulse on the edge that completes a word's last bit.

Behaviour:
- Reset: asynchronous on RST=1. State=IDLE, Q=IDLE_LEVEL, FRAME=0, DONE=0, bit counter=0, holding buffer empty. READY=1 after reset.
- State machine has two states, IDLE and SHIFT. The shift register is WIDTH bits and the counter is $clog2(WIDTH) bits.
- IDLE:
  - READY=1.
  - On VALID&&READY: shreg<=D, cnt<=WIDTH-1, next state SHIFT.
  - CE is ignored in the load cycle.
- SHIFT:
  - Q=shreg[WIDTH-1] (registered, glitch-free) and FRAME=1.
  - On a CE cycle, the bit on Q counts as transmitted; the receiver samples it at that edge.
  - If cnt!=0: shreg<={shreg[WIDTH-2:0],1'b0}, cnt<=cnt-1.
  - If cnt==0: DONE<=1 for one cycle. Then either reload from the next word (see Optional Feature) or return to IDLE. On return to IDLE, Q<=IDLE_LEVEL and FRAME<=0 on that same edge.
  - Without CE: shreg, cnt and Q are frozen, and each bit is held for as long as CE is absent.
- Latency:
  - First bit appears on Q the cycle after acceptance.
  - A word occupies exactly WIDTH CE cycles in SHIFT.
  - Minimum gap between words without the buffer is 1 IDLE cycle.
- Handshake:
  - READY is combinational from state and buffer status only, never from VALID or CE.
  - VALID while READY=0 is ignored; nothing is lost because the source holds D.
- Reset mid-word: the word is abandoned and the outputs return to reset values immediately. No DONE pulse is generated. The next accepted word transmits in full.
- Simultaneous events:
  - Acceptance and the final CE in the same cycle is handled per Optional Feature.
  - RST dominates everything.

Optional Feature:
Macro P2S_DOUBLE_BUFFER_EN.
- Defined:
  - Adds a one-word holding register plus a full flag, so READY = !hold_full.
  - A word accepted during SHIFT goes into the holding register.
  - On the completing CE edge with hold_full=1: shreg<=hold, cnt<=WIDTH-1, hold_full<=0. The state stays SHIFT, FRAME stays 1, DONE still pulses.
  - Words stream with zero gap.
  - Acceptance on the same cycle as the completing edge (hold empty) loads the new word directly into shreg.
  - An accept in IDLE bypasses the holding register.
- Undefined: READY = (state==IDLE), and there is no holding register.

Decomposition:
- Package p2s_pkg holds:
  - typedef enum p2s_state_t {IDLE, SHIFT}
  - function p2s_cnt_w(width) returning $clog2(width)
  - IDLE_LEVEL default constant
- One natural sub-module: p2s_hold_buffer (holding register, full flag, READY generation). It is instantiated only under P2S_DOUBLE_BUFFER_EN.

Test Plan:
1. WIDTH=8, CE=1 always, accept D=8'hA5 → Q over the next 8 cycles = 1,0,1,0,0,1,0,1. FRAME high for exactly 8 cycles, DONE pulses on the 8th edge. A looped-back serial-to-parallel receiver (same CLK/CE) holds 8'hA5.
2. CE=1 every 3rd cycle, D=8'h81 → each bit held 3 cycles, 24 cycles in SHIFT, Q=1 first and last bits. DONE only after the 8th CE.
3. No buffer: VALID held with D=8'h0F during SHIFT → READY=0 throughout and no acceptance. The word is accepted the cycle after FRAME falls and transmits 0,0,0,0,1,1,1,1.
4. P2S_DOUBLE_BUFFER_EN, CE=1, D=8'h3C then 8'hC3 back-to-back → 16 contiguous bits 00111100_11000011. FRAME never drops, DONE pulses twice, READY low only while the holding register is full.
5. RST pulsed mid-cycle after 3 bits of 8'hFF → Q=IDLE_LEVEL and FRAME=0 immediately (async), no DONE. After release READY=1, and 8'h55 transmits in full.
6. CE=0 held for 10 cycles mid-word → Q, FRAME and the counter are unchanged. Resuming CE completes the remaining bits correctly.
